cv32e40p_int_voter: RTL

Consumer side of the triplicated interrupt controller: takes the three independent output bundles (irq request/sec/id/wake-up plus MIP) and drives one voted bundle to cv32e40p_controller and cv32e40p_cs_registers. Sits between the triplicated interrupt controller and the core. Each lane has a fault-tracking state machine. A lane that keeps disagreeing with the vote is excluded from voting until software clears it.

---
 rtl/cv32e40p_pkg.sv | 20 ++
 rtl/cv32e40p_int_voter_lane.sv | 80 ++++++++
 rtl/cv32e40p_int_voter.sv | 89 ++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types for the triplicated interrupt voter
package cv32e40p_pkg;

  localparam int INT_VOTER_LANES = 3;

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } lane_state_e;

  typedef struct packed {
    logic        req;
    logic        sec;
    logic [4:0]  id;
    logic        wu;
    logic [31:0] mip;
  } irq_bundle_t;

endpackage

// File: rtl/cv32e40p_int_voter_lane.sv
// rtl/cv32e40p_int_voter_lane.sv - per-lane fault FSM and optional mismatch statistics
// Statistics counter present only when CV32E40P_INT_VOTER_STATS_EN is defined.
module cv32e40p_int_voter_lane
  import cv32e40p_pkg::*;
#(
  parameter int FAIL_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mismatch_i,
  input  logic        clear_i,
  output lane_state_e state_o,
  output logic [15:0] stat_cnt_o
);

  localparam logic [3:0] THRESH = FAIL_THRESH[3:0];

  lane_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = HEALTHY;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        HEALTHY: begin
          if (mismatch_i) begin
            cnt_d   = 4'd1;
            state_d = (THRESH == 4'd1) ? FAILED : SUSPECT;
          end
        end
        SUSPECT: begin
          if (mismatch_i) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == THRESH) state_d = FAILED;
          end else begin
            state_d = HEALTHY;
            cnt_d   = 4'd0;
          end
        end
        default: ;  // FAILED holds state and count until cleared
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HEALTHY;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

`ifdef CV32E40P_INT_VOTER_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (clear_i) stat_d = 16'd0;
    else if (mismatch_i && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= 16'd0;
    else        stat_q <= stat_d;
  end

  assign stat_cnt_o = stat_q;
`else
  assign stat_cnt_o = 16'd0;
`endif

endmodule

// File: rtl/cv32e40p_int_voter.sv
// rtl/cv32e40p_int_voter.sv - 3-lane interrupt bundle voter with lane fault exclusion
// Optional per-lane mismatch counters via CV32E40P_INT_VOTER_STATS_EN.
module cv32e40p_int_voter
  import cv32e40p_pkg::*;
#(
  parameter int FAIL_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  irq_req_i,
  input  logic [2:0]  irq_sec_i,
  input  logic [14:0] irq_id_i,
  input  logic [2:0]  irq_wu_i,
  input  logic [95:0] mip_i,
  input  logic        clear_faults_i,
  output logic        irq_req_ctrl_o,
  output logic        irq_sec_ctrl_o,
  output logic [4:0]  irq_id_ctrl_o,
  output logic        irq_wu_ctrl_o,
  output logic [31:0] mip_o,
  output logic [2:0]  lane_fail_o,
  output logic        err_uncorr_o,
  output logic        fatal_o,
  output logic [47:0] lane_mism_cnt_o
);

  irq_bundle_t lane_b     [INT_VOTER_LANES];
  lane_state_e lane_state [INT_VOTER_LANES];
  logic [15:0] stat_cnt   [INT_VOTER_LANES];
  logic [2:0]  lane_fail;
  logic [2:0]  mismatch;
  irq_bundle_t voted;
  logic        err_uncorr;
  logic [1:0]  n_failed;
  logic [1:0]  lo_idx, hi_idx;

  for (genvar n = 0; n < INT_VOTER_LANES; n++) begin : g_lane
    assign lane_b[n] = {irq_req_i[n], irq_sec_i[n], irq_id_i[5*n +: 5],
                        irq_wu_i[n], mip_i[32*n +: 32]};
    assign lane_fail[n] = (lane_state[n] == FAILED);
    // An unresolvable survivor disagreement blames nobody.
    assign mismatch[n] = !lane_fail[n] && (lane_b[n] != voted) && !err_uncorr;
    assign lane_mism_cnt_o[16*n +: 16] = stat_cnt[n];

    cv32e40p_int_voter_lane #(
      .FAIL_THRESH (FAIL_THRESH)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .mismatch_i (mismatch[n]),
      .clear_i    (clear_faults_i),
      .state_o    (lane_state[n]),
      .stat_cnt_o (stat_cnt[n])
    );
  end

  always_comb begin
    n_failed = {1'b0, lane_fail[0]} + {1'b0, lane_fail[1]} + {1'b0, lane_fail[2]};
    lo_idx   = 2'd0;
    hi_idx   = 2'd0;
    for (int i = INT_VOTER_LANES - 1; i >= 0; i--) begin
      if (!lane_fail[i]) lo_idx = 2'(i);
    end
    for (int i = 0; i < INT_VOTER_LANES; i++) begin
      if (!lane_fail[i]) hi_idx = 2'(i);
    end

    voted      = '0;
    err_uncorr = 1'b0;
    if (lane_fail == 3'b000) begin
      voted = irq_bundle_t'((lane_b[0] & lane_b[1]) | (lane_b[0] & lane_b[2]) |
                            (lane_b[1] & lane_b[2]));
    end else if (lane_fail != 3'b111) begin
      // lo == hi with a single survivor, so only the two-survivor case can flag
      voted      = lane_b[lo_idx];
      err_uncorr = (n_failed == 2'd1) && (lane_b[lo_idx] != lane_b[hi_idx]);
    end
  end

  assign irq_req_ctrl_o = voted.req;
  assign irq_sec_ctrl_o = voted.sec;
  assign irq_id_ctrl_o  = voted.id;
  assign irq_wu_ctrl_o  = voted.wu;
  assign mip_o          = voted.mip;
  assign err_uncorr_o   = err_uncorr;
  assign lane_fail_o    = lane_fail;
  assign fatal_o        = &lane_fail;

endmodule
